// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller read-response path.
package cc_pkg;

  localparam int CC_DATA_W = 64;
  localparam int CC_BEATS  = 8;
  localparam int CC_LINE_W = CC_DATA_W * CC_BEATS;
  localparam int CC_OFS_W  = $clog2(CC_BEATS);

  typedef enum logic {S_IDLE, S_SEND} cc_ser_state_t;

  // Layout of one hit-data FIFO entry, as written by the SRAM read side.
  typedef struct packed {
    logic [CC_OFS_W-1:0]  offset;
    logic [CC_LINE_W-1:0] line;
  } cc_line_entry_t;

endpackage

// File: rtl/cc_beat_mux.sv
// Combinational selection of one beat-sized slice out of a full cache line.
module cc_beat_mux #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int SEL_W  = $clog2(BEATS)
) (
  input  logic [DATA_W*BEATS-1:0] line,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       beat
);

  always_comb begin
    beat = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (sel == SEL_W'(i)) beat = line[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/cc_line_serializer.sv
// Serializes a cache line into a critical-word-first burst of BEATS beats,
// popping entries from a show-ahead hit-data FIFO with no bubble between bursts.
module cc_line_serializer
  import cc_pkg::*;
#(
  parameter int DATA_W = CC_DATA_W,
  parameter int BEATS  = CC_BEATS,
  parameter int LINE_W = DATA_W * BEATS,
  parameter int OFS_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_fifo_empty_i,
  input  logic [LINE_W+OFS_W-1:0] line_fifo_rdata_i,
  output logic                    line_fifo_rden_o,
  output logic [DATA_W-1:0]       inct_rdata_o,
  output logic                    inct_rlast_o,
  output logic                    inct_rvalid_o,
  input  logic                    inct_rready_i,
  output logic                    busy_o
);

  localparam logic [OFS_W-1:0] LAST = OFS_W'(BEATS - 1);

  cc_ser_state_t     state_p0, state_nxt;
  logic [OFS_W-1:0]  cnt_p0, cnt_nxt;
  logic [OFS_W-1:0]  ofs_p0;
  logic [LINE_W-1:0] line_p0;
  logic [OFS_W-1:0]  ptr;
  logic              vld_p0;
  logic              pop;

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    pop       = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (!line_fifo_empty_i) begin
          pop       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (inct_rready_i) begin
          if (cnt_p0 == LAST) begin
            // Chain straight into the next burst when another line is waiting.
            cnt_nxt = '0;
            if (!line_fifo_empty_i) pop = 1'b1;
            else                    state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt_p0 + OFS_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= '0;
      ofs_p0   <= '0;
      line_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (pop) begin
        line_p0 <= line_fifo_rdata_i[LINE_W-1:0];
        ofs_p0  <= line_fifo_rdata_i[LINE_W +: OFS_W];
      end
    end
  end

  // Output stage: everything below depends only on registered state.
  assign vld_p0 = (state_p0 == S_SEND);
  assign ptr    = ofs_p0 + cnt_p0;

  cc_beat_mux #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .SEL_W  (OFS_W)
  ) u_beat_mux (
    .line (line_p0),
    .sel  (ptr),
    .beat (inct_rdata_o)
  );

  assign inct_rvalid_o    = vld_p0;
  assign inct_rlast_o     = vld_p0 && (cnt_p0 == LAST);
  assign busy_o           = vld_p0;
  assign line_fifo_rden_o = pop;

endmodule
